// File: rtl/physics_pkg.sv
// ============================================================================
// Module      : physics_pkg
// Description : Shared sizes, sequencer state encoding and saturation helper
//               for the physics step sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package physics_pkg;

    localparam int c_num_nodes     = 8;
    localparam int c_position_size = 16;
    localparam int c_velocity_size = 16;
    localparam int c_force_size    = 16;
    localparam int c_dt_shift      = 1;
    localparam int c_gravity       = -4;
    localparam int c_floor_y       = 0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_COLLECT = 2'd2,
        S_DONE    = 2'd3
    } seq_state_t;

    // Clamp a wide signed value to the signed range of a narrower target width.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                      input int                 width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/node_integrator.sv
// ============================================================================
// Module      : node_integrator
// Description : Combinational semi-implicit Euler update for one node, with
//               gravity, saturation and floor clamp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module node_integrator
    import physics_pkg::*;
#(
    parameter int POSITION_SIZE = c_position_size,
    parameter int VELOCITY_SIZE = c_velocity_size,
    parameter int FORCE_SIZE    = c_force_size,
    parameter int DT_SHIFT      = c_dt_shift,
    parameter int GRAVITY       = c_gravity,
    parameter int FLOOR_Y       = c_floor_y
) (
    input  logic signed [FORCE_SIZE-1:0]    force_x,
    input  logic signed [FORCE_SIZE-1:0]    force_y,
    input  logic signed [VELOCITY_SIZE-1:0] vel_x,
    input  logic signed [VELOCITY_SIZE-1:0] vel_y,
    input  logic signed [POSITION_SIZE-1:0] pos_x,
    input  logic signed [POSITION_SIZE-1:0] pos_y,
    output logic signed [VELOCITY_SIZE-1:0] vel_x_next,
    output logic signed [VELOCITY_SIZE-1:0] vel_y_next,
    output logic signed [POSITION_SIZE-1:0] pos_x_next,
    output logic signed [POSITION_SIZE-1:0] pos_y_next
);

    logic signed [31:0] w_fx;
    logic signed [31:0] w_fy;
    logic signed [31:0] w_vx_sat;
    logic signed [31:0] w_vy_sat;
    logic signed [31:0] w_px_sat;
    logic signed [31:0] w_py_sat;
    logic               w_below_floor;

    // All arithmetic is carried at 32 bits so the sums cannot wrap before saturation.
    assign w_fx = 32'(force_x);
    assign w_fy = 32'(force_y) + GRAVITY;

    assign w_vx_sat = sat_signed(32'(vel_x) + (w_fx >>> DT_SHIFT), VELOCITY_SIZE);
    assign w_vy_sat = sat_signed(32'(vel_y) + (w_fy >>> DT_SHIFT), VELOCITY_SIZE);

    // Position uses the freshly updated velocity (semi-implicit Euler).
    assign w_px_sat = sat_signed(32'(pos_x) + (w_vx_sat >>> DT_SHIFT), POSITION_SIZE);
    assign w_py_sat = sat_signed(32'(pos_y) + (w_vy_sat >>> DT_SHIFT), POSITION_SIZE);

    assign w_below_floor = (w_py_sat < FLOOR_Y);

    assign vel_x_next = VELOCITY_SIZE'(w_vx_sat);
    assign pos_x_next = POSITION_SIZE'(w_px_sat);
    assign vel_y_next = w_below_floor ? '0 : VELOCITY_SIZE'(w_vy_sat);
    assign pos_y_next = w_below_floor ? POSITION_SIZE'(FLOOR_Y) : POSITION_SIZE'(w_py_sat);

endmodule

`default_nettype wire

// File: rtl/physics_step_sequencer.sv
// ============================================================================
// Module      : physics_step_sequencer
// Description : Holds per-node position/velocity state and runs one physics
//               step per frame_tick using forces streamed from the springs unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module physics_step_sequencer
    import physics_pkg::*;
#(
    parameter int NUM_NODES     = c_num_nodes,
    parameter int POSITION_SIZE = c_position_size,
    parameter int VELOCITY_SIZE = c_velocity_size,
    parameter int FORCE_SIZE    = c_force_size,
    parameter int DT_SHIFT      = c_dt_shift,
    parameter int GRAVITY       = c_gravity,
    parameter int FLOOR_Y       = c_floor_y
) (
    input  logic                                                 clk_in,
    input  logic                                                 rst_in,
    input  logic                                                 frame_tick,
    input  logic                                                 init_valid,
    input  logic        [$clog2(NUM_NODES)-1:0]                  init_idx,
    input  logic signed [POSITION_SIZE-1:0]                      init_x,
    input  logic signed [POSITION_SIZE-1:0]                      init_y,
    output logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]  nodes,
    output logic signed [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]  velocities,
    output logic                                                 springs_start,
    input  logic signed [FORCE_SIZE-1:0]                         spring_force_x,
    input  logic signed [FORCE_SIZE-1:0]                         spring_force_y,
    input  logic                                                 spring_force_valid,
    input  logic                                                 springs_done,
    output logic                                                 busy,
    output logic                                                 step_done,
    output logic                                                 overrun,
    output logic                                                 stream_error
);

    localparam int c_idx_w = $clog2(NUM_NODES);
    localparam int c_cnt_w = $clog2(NUM_NODES + 1);
    localparam logic [c_cnt_w-1:0] c_count_full = c_cnt_w'(NUM_NODES);

    seq_state_t r_state;
    seq_state_t w_next_state;

    logic signed [POSITION_SIZE-1:0] r_pos_x [NUM_NODES];
    logic signed [POSITION_SIZE-1:0] r_pos_y [NUM_NODES];
    logic signed [VELOCITY_SIZE-1:0] r_vel_x [NUM_NODES];
    logic signed [VELOCITY_SIZE-1:0] r_vel_y [NUM_NODES];

    logic [c_cnt_w-1:0] r_count;
    logic               r_overrun;
    logic               r_stream_error;
    logic               r_step_done;

    logic               w_step_done_pre;
    logic               w_beat_ok;
    logic [c_idx_w-1:0] w_beat_idx;
    logic [c_cnt_w-1:0] w_count_eff;

    logic signed [VELOCITY_SIZE-1:0] w_vx_next;
    logic signed [VELOCITY_SIZE-1:0] w_vy_next;
    logic signed [POSITION_SIZE-1:0] w_px_next;
    logic signed [POSITION_SIZE-1:0] w_py_next;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (frame_tick && !init_valid) w_next_state = S_START;
            S_START:   w_next_state = S_COLLECT;
            S_COLLECT: if (springs_done) w_next_state = S_DONE;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        springs_start   = 1'b0;
        busy            = 1'b1;
        w_step_done_pre = 1'b0;
        case (r_state)
            S_IDLE:  busy            = 1'b0;
            S_START: springs_start   = 1'b1;
            S_DONE:  w_step_done_pre = 1'b1;
            default: ;
        endcase
    end

    // Beats past the last node are dropped; the count stops at NUM_NODES.
    assign w_beat_ok   = (r_state == S_COLLECT) && spring_force_valid && (r_count < c_count_full);
    assign w_beat_idx  = r_count[c_idx_w-1:0];
    assign w_count_eff = r_count + c_cnt_w'(w_beat_ok);

    node_integrator #(
        .POSITION_SIZE (POSITION_SIZE),
        .VELOCITY_SIZE (VELOCITY_SIZE),
        .FORCE_SIZE    (FORCE_SIZE),
        .DT_SHIFT      (DT_SHIFT),
        .GRAVITY       (GRAVITY),
        .FLOOR_Y       (FLOOR_Y)
    ) u_integrator (
        .force_x    (spring_force_x),
        .force_y    (spring_force_y),
        .vel_x      (r_vel_x[w_beat_idx]),
        .vel_y      (r_vel_y[w_beat_idx]),
        .pos_x      (r_pos_x[w_beat_idx]),
        .pos_y      (r_pos_y[w_beat_idx]),
        .vel_x_next (w_vx_next),
        .vel_y_next (w_vy_next),
        .pos_x_next (w_px_next),
        .pos_y_next (w_py_next)
    );

    // ---------------- Node state, beat counter and status flags ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                r_pos_x[i] <= '0;
                r_pos_y[i] <= '0;
                r_vel_x[i] <= '0;
                r_vel_y[i] <= '0;
            end
            r_count        <= '0;
            r_overrun      <= 1'b0;
            r_stream_error <= 1'b0;
            r_step_done    <= 1'b0;
        end else begin
            r_step_done <= w_step_done_pre;

            if (r_state == S_IDLE && init_valid) begin
                r_pos_x[init_idx] <= init_x;
                r_pos_y[init_idx] <= init_y;
                r_vel_x[init_idx] <= '0;
                r_vel_y[init_idx] <= '0;
            end

            if (r_state == S_START) begin
                r_count <= '0;
            end else if (w_beat_ok) begin
                r_count             <= r_count + c_cnt_w'(1);
                r_vel_x[w_beat_idx] <= w_vx_next;
                r_vel_y[w_beat_idx] <= w_vy_next;
                r_pos_x[w_beat_idx] <= w_px_next;
                r_pos_y[w_beat_idx] <= w_py_next;
            end

            if (frame_tick && r_state != S_IDLE) begin
                r_overrun <= 1'b1;
            end

            if (r_state == S_COLLECT && springs_done && w_count_eff != c_count_full) begin
                r_stream_error <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_node_out
            assign nodes[0][gi]      = r_pos_x[gi];
            assign nodes[1][gi]      = r_pos_y[gi];
            assign velocities[0][gi] = r_vel_x[gi];
            assign velocities[1][gi] = r_vel_y[gi];
        end
    endgenerate

    assign step_done    = r_step_done;
    assign overrun      = r_overrun;
    assign stream_error = r_stream_error;

endmodule

`default_nettype wire

// File: tb/tb_physics_step_sequencer.sv
// ============================================================================
// Module      : tb_physics_step_sequencer
// Description : Randomised scoreboard bench for physics_step_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_physics_step_sequencer;

    localparam int N     = 8;
    localparam int PS    = 16;
    localparam int VS    = 16;
    localparam int FS    = 16;
    localparam int DT    = 1;
    localparam int GRAV  = -4;
    localparam int FLOOR = 0;

    logic                              clk_in = 1'b0;
    logic                              rst_in = 1'b1;
    logic                              frame_tick = 1'b0;
    logic                              init_valid = 1'b0;
    logic        [2:0]                 init_idx = '0;
    logic signed [PS-1:0]              init_x = '0;
    logic signed [PS-1:0]              init_y = '0;
    logic signed [1:0][N-1:0][PS-1:0]  nodes;
    logic signed [1:0][N-1:0][VS-1:0]  velocities;
    logic                              springs_start;
    logic signed [FS-1:0]              spring_force_x = '0;
    logic signed [FS-1:0]              spring_force_y = '0;
    logic                              spring_force_valid = 1'b0;
    logic                              springs_done = 1'b0;
    logic                              busy;
    logic                              step_done;
    logic                              overrun;
    logic                              stream_error;

    always #5 clk_in = ~clk_in;

    physics_step_sequencer #(
        .NUM_NODES(N), .POSITION_SIZE(PS), .VELOCITY_SIZE(VS), .FORCE_SIZE(FS),
        .DT_SHIFT(DT), .GRAVITY(GRAV), .FLOOR_Y(FLOOR)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_tick(frame_tick),
        .init_valid(init_valid), .init_idx(init_idx), .init_x(init_x), .init_y(init_y),
        .nodes(nodes), .velocities(velocities), .springs_start(springs_start),
        .spring_force_x(spring_force_x), .spring_force_y(spring_force_y),
        .spring_force_valid(spring_force_valid), .springs_done(springs_done),
        .busy(busy), .step_done(step_done), .overrun(overrun), .stream_error(stream_error)
    );

    typedef struct packed {
        logic                ovr;
        logic                serr;
        logic [N-1:0][15:0]  px;
        logic [N-1:0][15:0]  py;
        logic [N-1:0][15:0]  vx;
        logic [N-1:0][15:0]  vy;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: plain integer arithmetic
    int m_px[N], m_py[N], m_vx[N], m_vy[N];
    bit m_ovr, m_serr;
    int fx_tab[N], fy_tab[N];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int dpx(input int i); return int'($signed(nodes[0][i])); endfunction
    function automatic int dpy(input int i); return int'($signed(nodes[1][i])); endfunction
    function automatic int dvx(input int i); return int'($signed(velocities[0][i])); endfunction
    function automatic int dvy(input int i); return int'($signed(velocities[1][i])); endfunction

    function automatic int sat(input int v, input int w);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Floor division by 2^s
    function automatic int fdiv(input int a);
        int d = 1 << DT;
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_px[i] = 0; m_py[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
        end
        m_ovr = 0; m_serr = 0;
    endfunction

    function automatic void model_beat(input int i, input int fx, input int fy);
        if (i >= N) return;
        m_vx[i] = sat(m_vx[i] + fdiv(fx), VS);
        m_px[i] = sat(m_px[i] + fdiv(m_vx[i]), PS);
        m_vy[i] = sat(m_vy[i] + fdiv(fy + GRAV), VS);
        m_py[i] = sat(m_py[i] + fdiv(m_vy[i]), PS);
        if (m_py[i] < FLOOR) begin
            m_py[i] = FLOOR;
            m_vy[i] = 0;
        end
    endfunction

    function automatic void push_expected();
        exp_t e;
        e.ovr  = m_ovr;
        e.serr = m_serr;
        for (int i = 0; i < N; i++) begin
            e.px[i] = 16'(m_px[i]); e.py[i] = 16'(m_py[i]);
            e.vx[i] = 16'(m_vx[i]); e.vy[i] = 16'(m_vy[i]);
        end
        sb_q.push_back(e);
    endfunction

    function automatic void clear_tabs();
        for (int i = 0; i < N; i++) begin
            fx_tab[i] = 0; fy_tab[i] = 0;
        end
    endfunction

    function automatic void random_tabs();
        for (int i = 0; i < N; i++) begin
            fx_tab[i] = int'($urandom_range(0, 8000)) - 4000;
            fy_tab[i] = int'($urandom_range(0, 8000)) - 4000;
        end
    endfunction

    // Monitor: compares every committed step against the scoreboard
    always @(negedge clk_in) begin : mon
        exp_t e;
        if (!rst_in && step_done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_step_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                for (int i = 0; i < N; i++) begin
                    check($sformatf("n%0d_px", i), dpx(i), int'($signed(e.px[i])));
                    check($sformatf("n%0d_py", i), dpy(i), int'($signed(e.py[i])));
                    check($sformatf("n%0d_vx", i), dvx(i), int'($signed(e.vx[i])));
                    check($sformatf("n%0d_vy", i), dvy(i), int'($signed(e.vy[i])));
                end
                check("overrun", int'(overrun), int'(e.ovr));
                check("stream_error", int'(stream_error), int'(e.serr));
            end
        end
    end

    task automatic clear_inputs();
        spring_force_valid = 1'b0;
        frame_tick         = 1'b0;
        init_valid         = 1'b0;
        springs_done       = 1'b0;
    endtask

    task automatic do_init(input int idx, input int x, input int y);
        @(negedge clk_in);
        init_valid = 1'b1; init_idx = 3'(idx); init_x = 16'(x); init_y = 16'(y);
        @(negedge clk_in);
        init_valid = 1'b0;
        m_px[idx] = x; m_py[idx] = y; m_vx[idx] = 0; m_vy[idx] = 0;
    endtask

    task automatic run_step(input int nbeats, input bit tick_mid, input bit init_mid);
        int lat;
        @(negedge clk_in);
        frame_tick = 1'b1;
        @(negedge clk_in);
        frame_tick = 1'b0;
        check("start_pulse", int'(springs_start), 1);
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk_in);
            clear_inputs();
            if (i == 0) check("start_one_cycle", int'(springs_start), 0);
            repeat ($urandom_range(0, 1)) @(negedge clk_in);
            spring_force_valid = 1'b1;
            spring_force_x     = 16'(fx_tab[i]);
            spring_force_y     = 16'(fy_tab[i]);
            model_beat(i, fx_tab[i], fy_tab[i]);
            if (tick_mid && i == 1) begin
                frame_tick = 1'b1;
                m_ovr = 1;
            end
            if (init_mid && i == 2) begin
                init_valid = 1'b1;
                init_idx   = 3'($urandom_range(0, N - 1));
                init_x     = 16'($urandom_range(0, 500));
                init_y     = 16'($urandom_range(0, 500));
            end
        end
        @(negedge clk_in);
        clear_inputs();
        springs_done = 1'b1;
        if (nbeats != N) m_serr = 1;
        push_expected();
        @(negedge clk_in);
        springs_done = 1'b0;
        lat = 1;
        while (!step_done && lat < 10) begin
            @(negedge clk_in);
            lat++;
        end
        check("done_latency", lat, 2);
    endtask

    initial begin
        int pre_px7, pre_py7;
        model_reset();
        clear_tabs();
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("rst_px", dpx(i), 0); check("rst_py", dpy(i), 0);
            check("rst_vx", dvx(i), 0); check("rst_vy", dvy(i), 0);
        end
        check("rst_busy", int'(busy), 0);
        check("rst_start", int'(springs_start), 0);
        check("rst_step_done", int'(step_done), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_stream_error", int'(stream_error), 0);

        // Directed: basic step, floor clamp, saturation
        do_init(0, 100, 50);
        do_init(1, 0, 3);
        do_init(2, 0, 0);
        clear_tabs();
        fx_tab[0] = 8; fy_tab[1] = -8; fx_tab[2] = 32767;
        run_step(N, 0, 0);
        check("s1_n0_px", dpx(0), 102); check("s1_n0_py", dpy(0), 49);
        check("s1_n0_vx", dvx(0), 4);   check("s1_n0_vy", dvy(0), -2);
        check("s1_n1_py", dpy(1), 0);   check("s1_n1_vy", dvy(1), -6);

        clear_tabs();
        fx_tab[2] = 32754;
        run_step(N, 0, 0);
        check("s2_n1_py_clamp", dpy(1), 0);
        check("s2_n1_vy_clamp", dvy(1), 0);
        check("s2_n2_vx", dvx(2), 32760);

        clear_tabs();
        fx_tab[2] = 100;
        run_step(N, 0, 0);
        check("s3_n2_vx_sat", dvx(2), 32767);
        check("s3_n2_px_sat", dpx(2), 32767);

        // Init and tick together: init wins, tick dropped
        @(negedge clk_in);
        init_valid = 1'b1; init_idx = 3'd5; init_x = -16'sd7; init_y = 16'sd20;
        frame_tick = 1'b1;
        @(negedge clk_in);
        clear_inputs();
        m_px[5] = -7; m_py[5] = 20; m_vx[5] = 0; m_vy[5] = 0;
        check("init_tick_busy", int'(busy), 0);
        check("init_tick_start", int'(springs_start), 0);
        check("init_tick_px", dpx(5), -7);
        check("init_tick_overrun", int'(overrun), 0);

        // Tick during COLLECT, then a normal step; init while busy ignored
        random_tabs();
        run_step(N, 1, 0);
        check("overrun_set", int'(overrun), 1);
        random_tabs();
        run_step(N, 0, 1);

        // Short stream
        random_tabs();
        pre_px7 = m_px[N-1];
        pre_py7 = m_py[N-1];
        run_step(N - 1, 0, 0);
        check("short_stream_error", int'(stream_error), 1);
        check("short_last_px", dpx(N - 1), pre_px7);
        check("short_last_py", dpy(N - 1), pre_py7);

        // Reset in the middle of COLLECT
        @(negedge clk_in); frame_tick = 1'b1;
        @(negedge clk_in); frame_tick = 1'b0;
        @(negedge clk_in); spring_force_valid = 1'b1; spring_force_x = 16'sd300; spring_force_y = 16'sd40;
        @(negedge clk_in); spring_force_x = -16'sd50;
        @(negedge clk_in); clear_inputs(); rst_in = 1'b1;
        @(negedge clk_in); rst_in = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            check("mrst_px", dpx(i), 0); check("mrst_py", dpy(i), 0);
            check("mrst_vx", dvx(i), 0); check("mrst_vy", dvy(i), 0);
        end
        check("mrst_busy", int'(busy), 0);
        check("mrst_overrun", int'(overrun), 0);
        check("mrst_stream_error", int'(stream_error), 0);
        check("mrst_step_done", int'(step_done), 0);
        // Late springs_done from the abandoned run must be ignored
        @(negedge clk_in); springs_done = 1'b1;
        @(negedge clk_in); springs_done = 1'b0;
        check("late_done_busy", int'(busy), 0);
        do_init(3, 40, 60);
        random_tabs();
        run_step(N, 0, 0);

        // Randomised steps
        repeat (20) begin
            repeat ($urandom_range(0, 2)) begin
                do_init(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 4000)) - 2000,
                        int'($urandom_range(0, 4000)));
            end
            random_tabs();
            run_step(N, 0, 0);
        end

        repeat (4) @(negedge clk_in);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete, %0d checks so far", n_tests);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
